// File: rtl/patseq_pkg.sv
// Shared types and constants for the LCD test-pattern sequencer and its paint mux.
package patseq_pkg;

  typedef enum logic [1:0] {
    REL        = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } dbnc_state_t;

  localparam int PAT_COLOUR_SQ = 0;
  localparam int PAT_BARS      = 1;
  localparam int PAT_GRID      = 2;
  localparam int PAT_GRAD      = 3;

  localparam int NPAT_DEFAULT = 4;

  // Counter width that stays legal when the terminal count is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Frame/button/auto inputs and pattern outputs of the sequencer.
// PATSEQ_PREV_EN adds the btn_prev line.
interface pattern_sequencer_if #(
  parameter int NPAT = patseq_pkg::NPAT_DEFAULT
);
  logic                    frame;
  logic                    btn_next;
  logic                    auto_en;
`ifdef PATSEQ_PREV_EN
  logic                    btn_prev;
`endif
  logic [$clog2(NPAT)-1:0] pat;
  logic                    pat_stb;

`ifdef PATSEQ_PREV_EN
  modport master (output frame, btn_next, btn_prev, auto_en, input pat, pat_stb);
  modport slave  (input frame, btn_next, btn_prev, auto_en, output pat, pat_stb);
`else
  modport master (output frame, btn_next, auto_en, input pat, pat_stb);
  modport slave  (input frame, btn_next, auto_en, output pat, pat_stb);
`endif
endinterface

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> debounce FSM; emits a one-cycle press pulse.
// state      | meaning
// REL        | button released and stable
// PRESS_WAIT | went high, waiting DBNC_CYC stable cycles
// HELD       | press accepted, button still down
// REL_WAIT   | went low, waiting DBNC_CYC stable cycles
module btn_debounce
  import patseq_pkg::*;
#(
  parameter int DBNC_CYC = 90000
) (
  input  logic clk_pix,
  input  logic rst_pix_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = cnt_w(DBNC_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DBNC_CYC - 1);

  logic          sync_1, sync_2;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic          press_nxt;
  dbnc_state_t   state, state_nxt;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      state  <= REL;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      state  <= state_nxt;
      press  <= press_nxt;
      if (cnt_clr)
        cnt <= '0;
      else if (cnt != CNT_LAST)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    press_nxt = 1'b0;
    case (state)
      REL: if (sync_2) begin
        state_nxt = PRESS_WAIT;
        cnt_clr   = 1'b1;
      end
      PRESS_WAIT: if (!sync_2) begin
        state_nxt = REL;
      end else if (cnt == CNT_LAST) begin
        state_nxt = HELD;
        press_nxt = 1'b1;
      end
      HELD: if (!sync_2) begin
        state_nxt = REL_WAIT;
        cnt_clr   = 1'b1;
      end
      REL_WAIT: if (sync_2) begin
        state_nxt = HELD;
      end else if (cnt == CNT_LAST) begin
        state_nxt = REL;
      end
      default: state_nxt = REL;
    endcase
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous test-pattern selector: button or dwell timer requests, committed at frame start.
// PATSEQ_PREV_EN adds a debounced "previous pattern" button.
module pattern_sequencer
  import patseq_pkg::*;
#(
  parameter int NPAT     = NPAT_DEFAULT,
  parameter int DWELL    = 120,
  parameter int DBNC_CYC = 90000
) (
  input logic                 clk_pix,
  input logic                 rst_pix_n,
  pattern_sequencer_if.slave  bus
);

  localparam int PW = $clog2(NPAT);
  localparam int DW = cnt_w(DWELL);
  localparam logic [PW-1:0] PAT_LAST   = PW'(NPAT - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  logic          press_next;
  logic          any_press;
  logic          dwell_expire;
  logic          pending;
  logic          pat_stb_q;
  logic [DW-1:0] dwell_cnt;
  logic [PW-1:0] pat_q;
  logic [PW-1:0] pat_inc;

  btn_debounce #(.DBNC_CYC(DBNC_CYC)) u_dbnc_next (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .btn_raw   (bus.btn_next),
    .press     (press_next)
  );

  assign pat_inc = (pat_q == PAT_LAST) ? '0 : pat_q + 1'b1;

`ifdef PATSEQ_PREV_EN
  logic          press_prev;
  logic          pending_prev;
  logic [PW-1:0] pat_dec;

  btn_debounce #(.DBNC_CYC(DBNC_CYC)) u_dbnc_prev (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .btn_raw   (bus.btn_prev),
    .press     (press_prev)
  );

  assign any_press = press_next | press_prev;
  assign pat_dec   = (pat_q == '0) ? PAT_LAST : pat_q - 1'b1;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n)
      pending_prev <= 1'b0;
    else
      pending_prev <= (pending_prev & ~bus.frame) | press_prev;
  end
`else
  assign any_press = press_next;
`endif

  // Expiry only sets pending, so the advance lands on the frame after the DWELL-th.
  assign dwell_expire = bus.auto_en & bus.frame & (dwell_cnt == DWELL_LAST);

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n)
      dwell_cnt <= '0;
    else if (!bus.auto_en || any_press)
      dwell_cnt <= '0;
    else if (bus.frame)
      dwell_cnt <= (dwell_cnt == DWELL_LAST) ? '0 : dwell_cnt + 1'b1;
  end

  // A request arriving with the frame pulse survives the clear and commits next frame.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      pending   <= 1'b0;
      pat_q     <= '0;
      pat_stb_q <= 1'b0;
    end else begin
      pending   <= (pending & ~bus.frame) | press_next | dwell_expire;
      pat_stb_q <= 1'b0;
      if (bus.frame) begin
`ifdef PATSEQ_PREV_EN
        if (pending && !pending_prev) begin
          pat_q     <= pat_inc;
          pat_stb_q <= 1'b1;
        end else if (pending_prev && !pending) begin
          pat_q     <= pat_dec;
          pat_stb_q <= 1'b1;
        end
`else
        if (pending) begin
          pat_q     <= pat_inc;
          pat_stb_q <= 1'b1;
        end
`endif
      end
    end
  end

  assign bus.pat     = pat_q;
  assign bus.pat_stb = pat_stb_q;

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Frame-synchronous scheduler that selects which test pattern the paint logic renders on the 480x272 RGB LCD. It advances the pattern on a debounced button press or, in auto mode, after a programmable number of frames. Changes are committed only at frame start, so no frame ever mixes two patterns. It sits between the display timing generator (frame pulse) and the paint/colour mux in the top level.

Parameters:
NPAT, 4, number of patterns; pattern index wraps at NPAT-1; NPAT >= 2
DWELL, 120, frames per pattern in auto mode; DWELL >= 1
DBNC_CYC, 90000, clk_pix cycles the synchronised button must be stable before a level change is accepted (about 10 ms at 9 MHz)

Ports:
clk_pix  in  1  pixel clock; all logic is on the rising edge
rst_pix_n  in  1  asynchronous, active-low reset
frame  in  1  single-cycle pulse from the timing generator at frame start (first blanking line after active video)
btn_next  in  1  raw, asynchronous, active-high "next pattern" button
auto_en  in  1  level input; 1 = auto-advance every DWELL frames
pat  out  $clog2(NPAT)  current pattern index
pat_stb  out  1  one-cycle pulse in the cycle pat takes a new value

Behaviour:
- Reset (async assert, sync release inside clk_pix domain by design of the driver):
  - pat=0, pat_stb=0.
  - pending=0, dwell count=0.
  - Synchroniser flops=0; debounce FSM=REL.
- Button path:
  - 2-flop synchroniser, then a debounce FSM with states REL, PRESS_WAIT, HELD, REL_WAIT.
  - REL: on sync=1 go to PRESS_WAIT and clear the counter.
  - PRESS_WAIT: if sync=0, return to REL. If the count reaches DBNC_CYC-1 with sync=1, go to HELD and emit a one-cycle press event.
  - HELD: on sync=0 go to REL_WAIT and clear the counter.
  - REL_WAIT: if sync=1, return to HELD. If the count reaches DBNC_CYC-1 with sync=0, go to REL.
  - Counter width is $clog2(DBNC_CYC). The counter saturates and never wraps.
  - Latency from raw press to press event: 2 + DBNC_CYC cycles.
- Dwell path:
  - While auto_en=1, each frame pulse increments the dwell count.
  - When a frame pulse arrives with count==DWELL-1: count<=0 and pending<=1.
  - auto_en=0 holds the count at 0; a pending request already set is not cleared.
  - A press event also clears the dwell count, so a manual advance restarts the dwell.
- Pending and commit:
  - A press event or dwell expiry sets pending.
  - Multiple requests before a commit collapse into one advance.
  - On a frame pulse with pending=1 at the start of that cycle: pat <= (pat==NPAT-1) ? 0 : pat+1, pat_stb<=1 in the same registered update (visible the cycle after the frame pulse), pending<=0.
  - A request raised in the same cycle as a frame pulse is not applied on that frame. It stays pending and commits on the next frame pulse.
  - Frame pulse with pending=0: no change, pat_stb=0.
- The dwell expiry on a frame pulse sets pending for the next frame, never the current one. One advance per DWELL frames is therefore committed one frame late, consistently.
- pat_stb is high for exactly one cycle per change and never asserts outside the cycle following a frame pulse.

Optional Feature:
PATSEQ_PREV_EN
- Defined:
  - Adds input btn_prev (raw, active-high) with its own synchroniser and debouncer instance, setting pending_prev.
  - At commit, if exactly one of pending/pending_prev is set: advance or retreat (0 retreats to NPAT-1), with pat_stb=1.
  - If both are set: pat unchanged, pat_stb=0, both pending flags cleared.
  - A prev press also clears the dwell count.
- Undefined: no btn_prev port; behaviour exactly as above.

Decomposition:
- Package patseq_pkg:
  - Debounce state typedef (enum REL, PRESS_WAIT, HELD, REL_WAIT).
  - Pattern index localparams (PAT_COLOUR_SQ=0, PAT_BARS=1, PAT_GRID=2, PAT_GRAD=3) for the paint mux.
  - Default NPAT.
- Sub-module btn_debounce (synchroniser + FSM + counter, parameter DBNC_CYC, output press pulse). It is instantiated once, or twice with PATSEQ_PREV_EN.

Test Plan:
All scenarios use DBNC_CYC=4, DWELL=3, NPAT=4 and a frame pulse every 50 cycles.
- Reset mid-run with pat=2 and pending=1 -> pat=0, pat_stb=0 immediately; no change on the next frame.
- Button held 10 cycles, with a 2-cycle glitch beforehand -> exactly one press event, 6 cycles after the clean rise; pat 0->1 one cycle after the next frame, with pat_stb high for 1 cycle; the glitch is ignored.
- auto_en=1, no button, 14 frames -> pat sequence 0,1,2,3,0 with a strobe every 3 frames; the wrap from 3 to 0 is verified.
- Two presses within one frame period -> single advance (0->1).
- Press event coincident with a frame pulse -> no change on that frame; pat=1 after the following frame.
- PATSEQ_PREV_EN: prev at pat=0 -> pat=3. Next and prev both pending -> pat unchanged, no strobe, both flags cleared.
